// File: rtl/int_to_int_pkg.sv
// Shared definitions for the INT->INT conversion issue controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package int_to_int_pkg;

  localparam int DATA_W = 128;
  localparam int UOP_W  = 6;

  // Bit positions inside the 6-bit micro-op and the 7-bit cru word
  localparam int UOP_SRC_PREC   = 5;
  localparam int UOP_DST_PREC   = 4;
  localparam int UOP_SRC_SIGNED = 3;
  localparam int UOP_DST_SIGNED = 2;
  localparam int UOP_SRC_POS    = 1;
  localparam int UOP_DST_POS    = 0;
  localparam int CRU_VLD        = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Packs the array's micro-instruction word: valid flag above the uop bits
  function automatic logic [UOP_W:0] cru_word(input logic vld, input logic [UOP_W-1:0] uop);
    return {vld, uop};
  endfunction

endpackage

// File: rtl/int_to_int_res_fifo.sv
// Synchronous result FIFO, power-of-two depth, pointers wrap naturally.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module int_to_int_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/int_to_int_issue_ctrl.sv
// Issues source beats to the INT->INT array and returns its results through a credit-guarded FIFO.
// Latency: issue cycle -> array registers -> FIFO push -> res_vld, i.e. result visible 2 cycles after issue.
// Backpressure: src_rdy drops when queued + in-flight results would exceed the FIFO; res_rdy low holds res_data.
import int_to_int_pkg::*;

module int_to_int_issue_ctrl #(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [UOP_W-1:0]  cmd_uop,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              src_vld,
  output logic              src_rdy,
  input  logic [DATA_W-1:0] src_data,
  output logic [UOP_W:0]    cru_inttoint_out,
  output logic [DATA_W-1:0] dvr_inttoint_s_out,
  input  logic [DATA_W-1:0] dr_inttoint_d_in,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  logic [UOP_W-1:0]   uop_q;
  logic [LEN_W-1:0]   issue_cnt;
  logic [LEN_W-1:0]   retire_cnt;
  logic               inflight;
  logic               done_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [DATA_W-1:0]  fifo_head;
  logic [CW-1:0]      credit_used;
  logic               issue;
  logic               pop;
  logic               cmd_fire;

  // A beat in the array still owns a FIFO slot, so it counts against the credit
  assign credit_used = fifo_count + CW'(inflight);

  assign cmd_rdy  = (state == IDLE);
  assign cmd_fire = cmd_vld && cmd_rdy;
  assign src_rdy  = (state == RUN) && (issue_cnt != '0) && (credit_used < CW'(FIFO_DEPTH));
  assign issue    = src_vld && src_rdy;

  assign cru_inttoint_out   = cru_word(issue, uop_q);
  assign dvr_inttoint_s_out = issue ? src_data : '0;

  assign res_vld  = !fifo_empty;
  assign pop      = res_vld && res_rdy;
  assign res_data = fifo_empty ? '0 : fifo_head;
  assign res_last = res_vld && (retire_cnt == LEN_W'(1));
  assign busy     = (state != IDLE);
  assign done     = done_q;

  // Command FSM: latches the uop, tracks beats to issue and beats to retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      uop_q      <= '0;
      issue_cnt  <= '0;
      retire_cnt <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_len != '0) begin
              uop_q      <= cmd_uop;
              issue_cnt  <= cmd_len;
              retire_cnt <= cmd_len;
              state      <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            issue_cnt <= issue_cnt - LEN_W'(1);
            if (issue_cnt == LEN_W'(1)) state <= DRAIN;
          end
          if (pop) retire_cnt <= retire_cnt - LEN_W'(1);
        end
        DRAIN: begin
          if (pop) begin
            retire_cnt <= retire_cnt - LEN_W'(1);
            if (retire_cnt == LEN_W'(1)) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The array has a fixed one-cycle latency, so its output is pushed the cycle after issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= issue;
  end

  int_to_int_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (dr_inttoint_d_in),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The credit check on issue must make a push into a full FIFO impossible
  a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_int_to_int_issue_ctrl.sv
module tb_int_to_int_issue_ctrl;

  localparam int LEN_W = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [5:0]        cmd_uop;
  logic [LEN_W-1:0]  cmd_len;
  logic              src_vld;
  logic              src_rdy;
  logic [127:0]      src_data;
  logic [6:0]        cru_inttoint_out;
  logic [127:0]      dvr_inttoint_s_out;
  logic [127:0]      dr_inttoint_d_in;
  logic              res_vld;
  logic              res_rdy = 1'b1;
  logic [127:0]      res_data;
  logic              res_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  int_to_int_issue_ctrl #(.LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cmd_vld            (cmd_vld),
    .cmd_rdy            (cmd_rdy),
    .cmd_uop            (cmd_uop),
    .cmd_len            (cmd_len),
    .src_vld            (src_vld),
    .src_rdy            (src_rdy),
    .src_data           (src_data),
    .cru_inttoint_out   (cru_inttoint_out),
    .dvr_inttoint_s_out (dvr_inttoint_s_out),
    .dr_inttoint_d_in   (dr_inttoint_d_in),
    .res_vld            (res_vld),
    .res_rdy            (res_rdy),
    .res_data           (res_data),
    .res_last           (res_last),
    .busy               (busy),
    .done               (done)
  );

  // Stand-in lane transform for the conversion array (lane0 = [127:96])
  function automatic logic [127:0] lane_model(input logic [127:0] d, input logic [5:0] u);
    logic [127:0] r;
    logic [31:0]  l;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      l = d[127-32*i -: 32];
      r[127-32*i -: 32] = {l[30:0], l[31]} ^ {26'd0, u} ^ 32'(i);
    end
    return r;
  endfunction

  // Array model: registered output one cycle after a valid micro-instruction, garbage otherwise
  always @(posedge clk) begin
    if (cru_inttoint_out[6]) dr_inttoint_d_in <= lane_model(dvr_inttoint_s_out, cru_inttoint_out[5:0]);
    else                     dr_inttoint_d_in <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard state
  logic [127:0] exp_q[$];
  bit           last_q[$];
  int           cyc_q[$];
  int           cyc_cnt = 0;
  bit           lat_chk = 0;
  bit           sb_off  = 0;
  int           res_cnt = 0;
  int           acc_cnt = 0;
  int           feed_cycles = 0;
  logic [5:0]   cur_uop = '0;
  bit           res_mode = 0;
  logic         res_force = 1'b1;

  always @(posedge clk) cyc_cnt++;

  // res_rdy driver: forced level or random
  always @(posedge clk) begin
    #1;
    res_rdy = res_mode ? ($urandom_range(99) < 75) : res_force;
  end

  // Output monitor: pops expected results, checks hold stability and array drive
  logic [127:0] hold_data;
  bit           hold = 0;
  always @(negedge clk) begin
    logic [127:0] e;
    bit           l;
    int           c;
    if (!rst_n) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk_b("res_hold_vld", res_vld, 1'b1);
        chk("res_hold_data", res_data, hold_data);
      end
      hold      = res_vld && !res_rdy;
      hold_data = res_data;
      if (res_vld && res_rdy && !sb_off) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          chk_b("res_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          l = last_q.pop_front();
          c = cyc_q.pop_front();
          chk("res_data", res_data, e);
          chk_b("res_last", res_last, l);
          if (lat_chk) chk_i("res_latency", cyc_cnt - c, 2);
        end
      end
      if (busy) begin
        chk("cru", 128'(cru_inttoint_out), 128'({src_vld && src_rdy, cur_uop}));
        chk("dvr", dvr_inttoint_s_out, (src_vld && src_rdy) ? src_data : 128'd0);
      end else begin
        chk_b("cru_idle_vld", cru_inttoint_out[6], 1'b0);
      end
    end
  end

  task automatic send_cmd(input logic [5:0] uop, input int len);
    int t = 0;
    if (len != 0) cur_uop = uop;
    cmd_vld = 1'b1;
    cmd_uop = uop;
    cmd_len = LEN_W'(len);
    res_cnt = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_rdy && t < 50);
    if (!cmd_rdy) chk_b("cmd_rdy_timeout", cmd_rdy, 1'b1);
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic feed(input int len, input int pct, input bit toggle);
    int sent = 0;
    int k = 0;
    while (sent < len && k < len * 60 + 100) begin
      src_vld  = toggle ? (k % 2 == 0) : ($urandom_range(99) < pct);
      src_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      if (src_vld && src_rdy) begin
        exp_q.push_back(lane_model(src_data, cur_uop));
        last_q.push_back(sent == len - 1);
        cyc_q.push_back(cyc_cnt);
        sent++;
        acc_cnt++;
      end
      k++;
      @(posedge clk);
      #1;
    end
    src_vld     = 1'b0;
    src_data    = '0;
    feed_cycles = k;
    if (sent < len) chk_i("feed_timeout", sent, len);
  endtask

  task automatic wait_done(input int len);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < len * 60 + 200);
    chk_b("done_seen", done, 1'b1);
    chk_b("done_busy_low", busy, 1'b0);
    chk_b("done_cmd_rdy", cmd_rdy, 1'b1);
    chk_i("beat_count", res_cnt, len);
    @(negedge clk);
    chk_b("done_one_cycle", done, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_b({tag, "_cmd_rdy"}, cmd_rdy, 1'b1);
    chk_b({tag, "_src_rdy"}, src_rdy, 1'b0);
    chk({tag, "_cru"}, 128'(cru_inttoint_out), 128'd0);
    chk({tag, "_dvr"}, dvr_inttoint_s_out, 128'd0);
    chk_b({tag, "_res_vld"}, res_vld, 1'b0);
    chk({tag, "_res_data"}, res_data, 128'd0);
    chk_b({tag, "_res_last"}, res_last, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    cmd_vld  = 1'b0;
    cmd_uop  = '0;
    cmd_len  = '0;
    src_vld  = 1'b0;
    src_data = '0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic: 4 beats back to back, results 2 cycles after issue
    lat_chk = 1;
    send_cmd(6'b110000, 4);
    feed(4, 100, 0);
    chk_i("basic_issue_cycles", feed_cycles, 4);
    wait_done(4);
    lat_chk = 0;

    // Backpressure: only FIFO_DEPTH beats may issue while results are blocked
    res_force = 1'b0;
    @(posedge clk);
    #1;
    acc_cnt = 0;
    send_cmd(6'b101010, 8);
    fork
      feed(8, 100, 0);
      begin
        repeat (12) @(negedge clk);
        chk_i("bp_issued", acc_cnt, DEPTH);
        chk_b("bp_src_rdy", src_rdy, 1'b0);
        chk_b("bp_res_vld", res_vld, 1'b1);
        @(posedge clk);
        #1;
        res_force = 1'b1;
      end
    join
    wait_done(8);

    // Source bubbles: valid pattern 1,0,1,0,1 accepts 3 beats over 5 cycles
    send_cmd(6'b010101, 3);
    feed(3, 0, 1);
    chk_i("bubble_cycles", feed_cycles, 5);
    wait_done(3);

    // Zero length: done pulse only, no source or result activity
    send_cmd(6'b000011, 0);
    @(negedge clk);
    chk_b("zero_done", done, 1'b1);
    chk_b("zero_cmd_rdy", cmd_rdy, 1'b1);
    chk_b("zero_src_rdy", src_rdy, 1'b0);
    chk_b("zero_res_vld", res_vld, 1'b0);
    chk_b("zero_busy", busy, 1'b0);
    @(negedge clk);
    chk_b("zero_done_drop", done, 1'b0);
    chk_b("zero_res_vld2", res_vld, 1'b0);
    @(posedge clk);
    #1;

    // Reset during RUN after 3 issues
    sb_off  = 1;
    acc_cnt = 0;
    send_cmd(6'b011100, 10);
    src_vld  = 1'b1;
    src_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    for (int t = 0; t < 100 && acc_cnt < 3; t++) begin
      @(negedge clk);
      if (src_vld && src_rdy) acc_cnt++;
      @(posedge clk);
      #1;
    end
    chk_i("midrst_issued", acc_cnt, 3);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    src_vld = 1'b0;
    exp_q.delete();
    last_q.delete();
    cyc_q.delete();
    sb_off = 0;
    @(posedge clk);
    #1;
    send_cmd(6'b100001, 2);
    feed(2, 100, 0);
    wait_done(2);

    // Random commands with random source and sink stalls
    res_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      int len;
      logic [5:0] u;
      u   = 6'($urandom_range(63));
      len = $urandom_range(32, 1);
      send_cmd(u, len);
      feed(len, 75, 0);
      wait_done(len);
    end
    res_mode = 0;

    chk_i("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
